tcdm_banks_pipe_wrap: RTL and testbench
=======================================

TCDM_BANKS_PIPE_WRAP -- requirements
Module: tcdm_banks_pipe_wrap

Interface
REQ-001 SHALL have parameter BankSize, default 256, words per bank; power of 2, at least 2.
REQ-002 SHALL have parameter NbBanks, default 1, number of independent banks.
REQ-003 SHALL have parameter DataWidth, default 32, data bits per word.
REQ-004 SHALL have parameter AddrWidth, default 32, byte-address width per bank port.
REQ-005 SHALL have parameter BeWidth, default DataWidth/8, byte enables per word.
REQ-006 SHALL have parameter IdWidth, default 1, request id width.
REQ-007 SHALL have parameter Latency, default 1, range 1..4, cycles from granted request to response.
REQ-008 SHALL have parameter InitOnReset, default 1; when 1, the block zero-fills all banks after reset.
REQ-009 SHALL have clk_i, input, 1: clock; all state on rising edge.
REQ-010 SHALL have rst_ni, input, 1: reset, asynchronous, active-low.
REQ-011 SHALL have test_mode_i, input, 1: when high, skips or aborts the init fill.
REQ-012 SHALL have req_i, input, NbBanks: per-bank request.
REQ-013 SHALL have gnt_o, output, NbBanks: per-bank grant.
REQ-014 SHALL have wen_i, input, NbBanks: 1 = read, 0 = write.
REQ-015 SHALL have add_i, input, NbBanks x AddrWidth: byte address.
REQ-016 SHALL have data_i, input, NbBanks x DataWidth: write data.
REQ-017 SHALL have be_i, input, NbBanks x BeWidth: byte enables.
REQ-018 SHALL have id_i, input, NbBanks x IdWidth: request id.
REQ-019 SHALL have r_data_o, output, NbBanks x DataWidth: read data.
REQ-020 SHALL have r_valid_o, output, NbBanks: response valid.
REQ-021 SHALL have r_id_o, output, NbBanks x IdWidth: response id.
REQ-022 SHALL have init_done_o, output, 1: high once the init fill is complete or skipped.

Function
REQ-023 SHALL run one shared FSM with states INIT and READY.
REQ-024 SHALL leave reset in INIT if InitOnReset=1 and test_mode_i=0; otherwise in READY.
REQ-025 In INIT, SHALL write all-zero data with all byte enables set to word index cnt in every bank, one word per cycle; cnt counts 0..BankSize-1.
REQ-026 SHALL go from INIT to READY in the cycle after cnt=BankSize-1 is written; there is no wrap and no restart.
REQ-027 In INIT, SHALL abort to READY on the next edge when test_mode_i=1; words not yet written keep their prior contents.
REQ-028 SHALL hold gnt_o=0 and ignore req_i for all banks in INIT; no response is generated for requests in INIT.
REQ-029 In READY, SHALL hold gnt_o=1 for every bank, regardless of req_i.
REQ-030 SHALL treat a handshake as req_i & gnt_o per bank; banks are fully independent.
REQ-031 SHALL use word index add_i[$clog2(BankSize)+1:2]; other address bits are ignored.
REQ-032 SHALL write only the bytes whose be_i bit is 1 on a write handshake.
REQ-033 SHALL assert r_valid_o exactly Latency cycles after every handshake, read or write; r_valid_o is high for one cycle per handshake.
REQ-034 SHALL present r_id_o equal to the handshake's id_i in the same cycle as r_valid_o.
REQ-035 SHALL present r_data_o with the word contents before any same-cycle write when r_valid_o is high for a read; r_data_o is undefined for write responses.
REQ-036 SHALL accept back-to-back handshakes every cycle; the response pipeline holds Latency entries per bank and needs no backpressure.
REQ-037 SHALL return a read's data that includes a write handshaked N cycles earlier (N at least 1), for any Latency.
REQ-038 SHALL drive r_valid_o, r_id_o and init_done_o only from registers.

Reset
REQ-039 On rst_ni=0, SHALL set cnt=0, clear all r_valid_o and r_id_o to 0, set init_done_o=0, and clear gnt_o to 0.
REQ-040 SHALL drop in-flight responses on reset mid-operation, and restart the init fill mid-INIT from cnt=0.
REQ-041 SHALL not reset memory contents.

Verification
REQ-042 Fill check: InitOnReset=1, BankSize=256, test_mode_i=0, release reset -> gnt_o=0 for 256 cycles, then init_done_o=1 and gnt_o all 1; reads of words 0, 128 and 255 return 0.
REQ-043 Skip and abort: test_mode_i=1 at reset release -> init_done_o=1 and gnt_o=1 on the first cycle; test_mode_i raised at cnt=10 -> READY on the next edge.
REQ-044 Latency sweep: Latency=1..4, write 0xA5A5A5A5 to word 3 with id=1, then read word 3 with id=0 on the next cycle -> r_valid_o at T+L and T+L+1; second response has r_id_o=0 and r_data_o=0xA5A5A5A5.
REQ-045 Byte enables: word = 0x00000000, write 0xFFFFFFFF with be=0b0101 -> a read returns 0x00FF00FF.
REQ-046 Streaming and banks: NbBanks=4, reads every cycle for 64 cycles on all banks with distinct ids -> 64 in-order responses per bank, ids matched, no drops.
REQ-047 Reset mid-stream: assert rst_ni=0 with 3 reads in flight -> no r_valid_o after reset release, and the init fill restarts.

Source files
------------

// File: rtl/tcdm_banks_pipe_wrap_if.sv
// Per-bank TCDM request/response bundle shared by the bank wrapper and its requestor.
// Every signal is a packed per-bank vector, so bank b lives in index [b].
interface tcdm_banks_pipe_wrap_if #(
  parameter int unsigned NbBanks   = 1,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned BeWidth   = DataWidth / 8,
  parameter int unsigned IdWidth   = 1
);
  logic [NbBanks-1:0]                req_i;
  logic [NbBanks-1:0]                gnt_o;
  logic [NbBanks-1:0]                wen_i;
  logic [NbBanks-1:0][AddrWidth-1:0] add_i;
  logic [NbBanks-1:0][DataWidth-1:0] data_i;
  logic [NbBanks-1:0][BeWidth-1:0]   be_i;
  logic [NbBanks-1:0][IdWidth-1:0]   id_i;
  logic [NbBanks-1:0][DataWidth-1:0] r_data_o;
  logic [NbBanks-1:0]                r_valid_o;
  logic [NbBanks-1:0][IdWidth-1:0]   r_id_o;

  modport master (
    output req_i, wen_i, add_i, data_i, be_i, id_i,
    input  gnt_o, r_data_o, r_valid_o, r_id_o
  );

  modport slave (
    input  req_i, wen_i, add_i, data_i, be_i, id_i,
    output gnt_o, r_data_o, r_valid_o, r_id_o
  );
endinterface

// File: rtl/tcdm_banks_pipe_wrap.sv
// Independent single-port TCDM banks with a fixed-latency response pipeline and an
// optional zero-fill of every bank after reset, sequenced by one shared INIT/READY FSM.
module tcdm_banks_pipe_wrap #(
  parameter int unsigned BankSize    = 256,
  parameter int unsigned NbBanks     = 1,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned BeWidth     = DataWidth / 8,
  parameter int unsigned IdWidth     = 1,
  parameter int unsigned Latency     = 1,
  parameter int unsigned InitOnReset = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_mode_i,
  tcdm_banks_pipe_wrap_if.slave bus,
  output logic                  init_done_o
);
  localparam int unsigned IdxW = $clog2(BankSize);

  typedef enum logic {INIT, READY} state_e;

  state_e                          state_q, state_d;
  logic [IdxW-1:0]                 cnt_q, cnt_d;
  logic                            init_wr;
  logic [NbBanks-1:0]              hs;
  logic [NbBanks-1:0][IdxW-1:0]    idx;
  logic                            addr_unused;
  logic [DataWidth-1:0]            mem_q [NbBanks][BankSize];

  logic [NbBanks-1:0]                vld_p   [Latency];
  logic [NbBanks-1:0][IdWidth-1:0]   id_p    [Latency];
  logic [NbBanks-1:0][DataWidth-1:0] rdata_p [Latency];

  // Fill sequencer: one zero word per cycle into every bank; test mode aborts without writing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    init_wr = 1'b0;
    case (state_q)
      INIT: begin
        if (test_mode_i || (InitOnReset == 0)) begin
          state_d = READY;
        end else begin
          init_wr = 1'b1;
          cnt_d   = cnt_q + IdxW'(1);
          if (cnt_q == IdxW'(BankSize - 1)) state_d = READY;
        end
      end
      READY: state_d = READY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_o <= (state_d == READY);
    end
  end

  assign bus.gnt_o = {NbBanks{state_q == READY}};
  assign hs        = bus.req_i & bus.gnt_o;
  assign addr_unused = ^bus.add_i;

  always_comb begin
    for (int b = 0; b < NbBanks; b++) idx[b] = bus.add_i[b][IdxW+1:2];
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NbBanks; b++) begin
      if (init_wr) begin
        mem_q[b][cnt_q] <= '0;
      end else if (hs[b] && !bus.wen_i[b]) begin
        for (int k = 0; k < BeWidth; k++) begin
          if (bus.be_i[b][k]) mem_q[b][idx[b]][8*k +: 8] <= bus.data_i[b][8*k +: 8];
        end
      end
    end
  end

  // Stage 0 captures the handshake and the pre-write word; later stages only delay.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < Latency; s++) begin
        vld_p[s] <= '0;
        id_p[s]  <= '0;
      end
    end else begin
      vld_p[0] <= hs;
      id_p[0]  <= bus.id_i;
      for (int s = 1; s < Latency; s++) begin
        vld_p[s] <= vld_p[s-1];
        id_p[s]  <= id_p[s-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NbBanks; b++) rdata_p[0][b] <= mem_q[b][idx[b]];
    for (int s = 1; s < Latency; s++) rdata_p[s] <= rdata_p[s-1];
  end

  // Output boundary: the last stage drives the response directly.
  assign bus.r_valid_o = vld_p[Latency-1];
  assign bus.r_id_o    = id_p[Latency-1];
  assign bus.r_data_o  = rdata_p[Latency-1];
endmodule

// File: tb/tb_tcdm_banks_pipe_wrap.sv
// Drives four 4-bank wrappers (Latency 1..4) with identical stimulus and checks each
// against a transaction-level memory and response-schedule model.
module tb_tcdm_banks_pipe_wrap;
  localparam int NB = 4;
  localparam int BS = 256;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = 4;
  localparam int IW = 4;
  localparam int NL = 4;

  typedef struct {
    int            due;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    bit            rd;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic test_mode;
  logic [NB-1:0]         req, wen;
  logic [NB-1:0][AW-1:0] add;
  logic [NB-1:0][DW-1:0] wdata;
  logic [NB-1:0][BW-1:0] be;
  logic [NB-1:0][IW-1:0] id;

  logic [NB-1:0]         gnt_w   [NL];
  logic [NB-1:0]         rv_w    [NL];
  logic [NB-1:0][DW-1:0] rd_w    [NL];
  logic [NB-1:0][IW-1:0] rid_w   [NL];
  logic                  idone_w [NL];

  int    n_assert = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    m_ready;
  int    m_cnt;
  logic [DW-1:0] mem_m [NB][BS];
  resp_t sbq [NL*NB][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    tcdm_banks_pipe_wrap_if #(.NbBanks(NB), .DataWidth(DW), .AddrWidth(AW),
                              .BeWidth(BW), .IdWidth(IW)) bus ();
    assign bus.req_i  = req;
    assign bus.wen_i  = wen;
    assign bus.add_i  = add;
    assign bus.data_i = wdata;
    assign bus.be_i   = be;
    assign bus.id_i   = id;
    assign gnt_w[g]   = bus.gnt_o;
    assign rv_w[g]    = bus.r_valid_o;
    assign rd_w[g]    = bus.r_data_o;
    assign rid_w[g]   = bus.r_id_o;

    tcdm_banks_pipe_wrap #(.BankSize(BS), .NbBanks(NB), .DataWidth(DW), .AddrWidth(AW),
                           .BeWidth(BW), .IdWidth(IW), .Latency(g + 1), .InitOnReset(1)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .test_mode_i (test_mode),
      .bus         (bus),
      .init_done_o (idone_w[g])
    );
  end

  task automatic check(input string tag, input int g, input int b,
                       input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lat=%0d bank=%0d observed=%0h expected=%0h", tag, g + 1, b, obs, exp);
    end
  endtask

  task automatic set_all(input bit r, input bit w, input int word, input logic [DW-1:0] d,
                         input logic [BW-1:0] bev, input logic [IW-1:0] idv);
    for (int b = 0; b < NB; b++) begin
      req[b]      = r;
      wen[b]      = w;
      add[b]      = $urandom;
      add[b][9:2] = 8'(word);
      wdata[b]    = d;
      be[b]       = bev;
      id[b]       = idv;
    end
  endtask

  task automatic rand_inputs(input int max_word);
    for (int b = 0; b < NB; b++) begin
      req[b]      = 1'($urandom_range(0, 1));
      wen[b]      = 1'($urandom_range(0, 1));
      add[b]      = $urandom;
      add[b][9:2] = 8'($urandom_range(0, max_word));
      wdata[b]    = $urandom;
      be[b]       = 4'($urandom);
      id[b]       = 4'($urandom);
    end
  endtask

  task automatic check_idle_outputs();
    for (int g = 0; g < NL; g++) begin
      check("rst_init_done", g, 0, 32'(idone_w[g]), 32'd0);
      for (int b = 0; b < NB; b++) begin
        check("rst_gnt", g, b, 32'(gnt_w[g][b]), 32'd0);
        check("rst_r_valid", g, b, 32'(rv_w[g][b]), 32'd0);
        check("rst_r_id", g, b, 32'(rid_w[g][b]), 32'd0);
      end
    end
  endtask

  task automatic tick();
    resp_t e;
    int    w;
    bit    expv;
    for (int b = 0; b < NB; b++) begin
      if (req[b] && m_ready) begin
        w = int'(add[b][9:2]);
        for (int g = 0; g < NL; g++) begin
          e.due  = cyc + g + 1;
          e.id   = id[b];
          e.data = mem_m[b][w];
          e.rd   = wen[b];
          sbq[g*NB + b].push_back(e);
        end
        if (!wen[b])
          for (int k = 0; k < BW; k++)
            if (be[b][k]) mem_m[b][w][8*k +: 8] = wdata[b][8*k +: 8];
      end
    end
    if (!m_ready) begin
      if (test_mode) m_ready = 1'b1;
      else begin
        for (int b = 0; b < NB; b++) mem_m[b][m_cnt] = '0;
        if (m_cnt == BS - 1) m_ready = 1'b1;
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int g = 0; g < NL; g++) begin
      check("init_done", g, 0, 32'(idone_w[g]), 32'(m_ready));
      for (int b = 0; b < NB; b++) begin
        check("gnt", g, b, 32'(gnt_w[g][b]), 32'(m_ready));
        expv = (sbq[g*NB + b].size() > 0) && (sbq[g*NB + b][0].due == cyc);
        check("r_valid", g, b, 32'(rv_w[g][b]), 32'(expv));
        if (expv) begin
          e = sbq[g*NB + b].pop_front();
          check("r_id", g, b, 32'(rid_w[g][b]), 32'(e.id));
          if (e.rd) check("r_data", g, b, rd_w[g][b], e.data);
        end
      end
    end
  endtask

  task automatic do_reset(input bit tm);
    rst_n     = 1'b0;
    test_mode = tm;
    req       = '0;
    m_ready   = 1'b0;
    m_cnt     = 0;
    for (int i = 0; i < NL*NB; i++) sbq[i].delete();
    #1;
    check_idle_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    check_idle_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req = '0;
    repeat (NL + 2) tick();
  endtask

  initial begin
    req = '0; wen = '0; add = '0; wdata = '0; be = '0; id = '0;
    do_reset(1'b0);

    // Zero fill with random (ignored) requests; grant must stay low for all 256 cycles.
    for (int c = 0; c < BS; c++) begin
      rand_inputs(255);
      tick();
    end
    req = '0;

    foreach (mem_m[b, w]) if (mem_m[b][w] !== '0) $display("model fill incomplete at bank %0d word %0d", b, w);
    set_all(1, 1, 0, '0, '1, 4'd1);   tick();
    set_all(1, 1, 128, '0, '1, 4'd2); tick();
    set_all(1, 1, 255, '0, '1, 4'd3); tick();
    drain();

    // Write then read the same word on consecutive cycles.
    set_all(1, 0, 3, 32'hA5A5A5A5, 4'hF, 4'd1); tick();
    set_all(1, 1, 3, 32'h0, 4'hF, 4'd0);        tick();
    drain();

    // Partial byte-enable write over a zero word.
    set_all(1, 0, 5, 32'h0, 4'hF, 4'd4);        tick();
    set_all(1, 0, 5, 32'hFFFFFFFF, 4'b0101, 4'd5); tick();
    set_all(1, 1, 5, 32'h0, 4'hF, 4'd6);        tick();
    drain();

    // Streaming reads on every bank, every cycle, distinct ids across banks.
    for (int c = 0; c < 64; c++) begin
      set_all(1, 1, int'($urandom_range(0, 255)), '0, '1, '0);
      for (int b = 0; b < NB; b++) id[b] = 4'((c * NB + b) % 16);
      tick();
    end
    drain();

    // Random mix of reads and writes over a small window to force reuse.
    for (int c = 0; c < 300; c++) begin
      rand_inputs(31);
      tick();
    end
    drain();

    // Reset with reads in flight, then abort the restarted fill at cnt=10.
    for (int c = 0; c < 3; c++) begin
      set_all(1, 1, c + 4, '0, '1, 4'(c + 7));
      tick();
    end
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      rand_inputs(31);
      tick();
    end
    req = '0;
    test_mode = 1'b1;
    tick();
    test_mode = 1'b0;
    for (int w = 0; w < 21; w++) begin
      set_all(1, 1, w, '0, '1, 4'(w));
      tick();
    end
    drain();

    // Init skipped entirely when test mode is held through reset release.
    do_reset(1'b1);
    set_all(1, 0, 7, 32'h12345678, 4'hF, 4'd9);
    tick();
    test_mode = 1'b0;
    set_all(1, 1, 7, '0, '1, 4'd10);
    tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
